nios_led_driver: RTL and testbench
==================================

# nios_led_driver

Output-conditioning stage directly downstream of the Nios LED PIO: takes the PIO's 5-bit LED pattern and drives the board LED pins with global PWM brightness and optional synchronous blink. Has its own small Avalon-MM slave so software sets brightness, blink rate and enable without touching the pattern register. Single clock domain, zero-wait-state reads, same bus flavour as the PIO.

## Interface
- WIDTH, 5: number of LEDs; matches the PIO output width.
- PWM_BITS, 8: brightness resolution and PWM counter width.
- DIV_BITS, 24: blink prescaler width.
- DIV_RESET, 24'd4999999: blink prescaler reset reload value; gives a 5 Hz blink at 50 MHz.
- clk  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- led_in  in  WIDTH  pattern from the PIO out_port, same clock domain.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read data; unused bits are 0.
- led_out  out  WIDTH  LED pin drive, active-high.

## Operation
- Register map (word addresses):
  - 0 CTRL: bit0 EN (reset 1), bit1 BLINK (reset 0).
  - 1 BRIGHT: bits[PWM_BITS-1:0], reset all-ones.
  - 2 DIV: bits[DIV_BITS-1:0], reset DIV_RESET.
  - 3 STATUS: read-only. bits[WIDTH-1:0] = led_out, bit8 = phase. Writes are ignored.
- A write takes effect when chipselect && !write_n. Only the low field bits are stored; upper writedata bits are ignored.
- Input stage: led_in is registered into pat_q each cycle. pat_q resets to 0.
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter that wraps 2^PWM_BITS-1 to 0. It resets to 0.
  - pwm_on = (BRIGHT == all-ones) || (pwm_cnt < BRIGHT).
  - BRIGHT=0 gives always off. All-ones gives always on, not 255/256.
- Blink prescaler:
  - div_cnt loads DIV when it reaches 0, otherwise it decrements.
  - On the cycle it is 0, phase toggles.
  - DIV=0 toggles phase every cycle.
  - phase resets to 1.
  - A write to DIV loads div_cnt with the new value and forces phase=1 on the next edge. This overrides the same-cycle toggle.
- Output: led_out (registered) = pat_q & {WIDTH{EN & pwm_on & (~BLINK | phase)}}.
- Clearing BLINK gives steady output immediately. The prescaler keeps running.
- Clearing EN forces led_out=0 from the next edge. Counters keep running.
- Reads:
  - Address 0 returns {30'b0, BLINK, EN}.
  - Address 1 returns BRIGHT, zero-extended.
  - Address 2 returns DIV, zero-extended.
  - Address 3 returns STATUS.
  - readdata is valid in the same cycle regardless of chipselect, as in the PIO.

## Timing
- led_in to led_out latency: 2 cycles (pat_q, then the output register) when pwm_on and the blink gate are true.
- Register write to effect on led_out: 1 cycle after the write edge.
- Reset assertion: all registers go to their reset values immediately and led_out=0, even mid-PWM-period or mid-blink.
- After release, the first led_out update is on the second rising edge.
- PWM period is 2^PWM_BITS cycles. High time per period is exactly BRIGHT cycles, or the full period at all-ones.
- Blink half-period is DIV+1 cycles.

## Structure
- Package nios_led_driver_pkg holds:
  - register address constants ADDR_CTRL/ADDR_BRIGHT/ADDR_DIV/ADDR_STATUS;
  - CTRL bit indices EN_BIT/BLINK_BIT;
  - STATUS phase bit index 8;
  - reset values of CTRL and BRIGHT.
- One sub-module, led_pwm_gen: owns pwm_cnt and the compare logic. Input bright, output pwm_on, parameter PWM_BITS.
- Register file, prescaler and output gating live in the top.

## Test plan
- Reset defaults: hold reset_n=0, drive led_in=5'h1F.
  - During reset: led_out=0 and reads return CTRL=1, BRIGHT=0xFF, DIV=DIV_RESET.
  - After release: led_out=5'h1F on the second edge.
- Pass-through: led_in 5'h0A→5'h15 at cycle t → led_out=5'h15 at t+2, with no glitch cycle.
- PWM duty, BRIGHT=64 (PWM_BITS=8):
  - Count led_out[0] high cycles over 512 cycles = 128 exactly.
  - BRIGHT=0 gives 0 high cycles.
  - BRIGHT=255 gives 512 high cycles.
- Blink, DIV=3, CTRL=3, BRIGHT=0xFF, led_in=5'h01:
  - led_out[0] alternates 4 cycles on / 4 off.
  - A DIV write mid-off-phase restores on at the next edge.
- Disable and mid-operation reset:
  - CTRL=0 → led_out=0 one edge later, while STATUS still reads phase toggling.
  - Assert reset_n mid-period → led_out=0 asynchronously, and pwm_cnt restarts at 0.
- Bus edges:
  - A write to STATUS changes nothing.
  - A write with chipselect=0 changes nothing.
  - A DIV write of 32'hFFFFFFFF stores 24'hFFFFFF.

Source files
------------

// File: rtl/nios_led_driver_pkg.sv
// Shared constants for the Nios LED output-conditioning stage:
// register map, CTRL/STATUS bit positions and register reset values.
package nios_led_driver_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_BRIGHT = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int EN_BIT    = 0;
  localparam int BLINK_BIT = 1;
  localparam int PHASE_BIT = 8;

  // CTRL resets with EN=1, BLINK=0 so LEDs follow the PIO out of reset.
  localparam logic [1:0] CTRL_RESET = 2'b01;

  // All-ones at any width; the top slices off the low PWM_BITS.
  localparam logic [31:0] BRIGHT_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/nios_led_driver_pwm.sv
// Global brightness PWM: free-running counter compared against BRIGHT.
// All-ones brightness is treated as fully on rather than (2^N-1)/2^N.
module led_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PWM_BITS-1:0] bright,
  output logic                pwm_on
);

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                w_full_on;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + {{(PWM_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign w_full_on = &bright;
  assign pwm_on    = w_full_on | (r_pwm_cnt < bright);

endmodule

// File: rtl/nios_led_driver.sv
// LED pin driver behind the Nios LED PIO: registers the pattern, applies
// PWM brightness, enable and synchronous blink, with a small Avalon-MM slave.
module nios_led_driver
  import nios_led_driver_pkg::*;
#(
  parameter int                  WIDTH     = 5,
  parameter int                  PWM_BITS  = 8,
  parameter int                  DIV_BITS  = 24,
  parameter logic [DIV_BITS-1:0] DIV_RESET = 24'd4999999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] led_in,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] led_out
);

  logic                w_wr;
  logic                w_wr_ctrl;
  logic                w_wr_bright;
  logic                w_wr_div;
  logic                w_pwm_on;
  logic                w_gate;
  logic                w_unused_wdata;
  logic [31:0]         w_rdata;

  logic                r_en;
  logic                r_blink;
  logic [PWM_BITS-1:0] r_bright;
  logic [DIV_BITS-1:0] r_div;
  logic [DIV_BITS-1:0] r_div_cnt;
  logic                r_phase;
  logic [WIDTH-1:0]    r_pat;
  logic [WIDTH-1:0]    r_led_out;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_ctrl   = w_wr & (address == ADDR_CTRL);
  assign w_wr_bright = w_wr & (address == ADDR_BRIGHT);
  assign w_wr_div    = w_wr & (address == ADDR_DIV);

  // Only the low field bits of each register are stored.
  assign w_unused_wdata = ^writedata[31:DIV_BITS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en     <= CTRL_RESET[EN_BIT];
      r_blink  <= CTRL_RESET[BLINK_BIT];
      r_bright <= BRIGHT_RESET[PWM_BITS-1:0];
      r_div    <= DIV_RESET;
    end else begin
      if (w_wr_ctrl) begin
        r_en    <= writedata[EN_BIT];
        r_blink <= writedata[BLINK_BIT];
      end
      if (w_wr_bright) begin
        r_bright <= writedata[PWM_BITS-1:0];
      end
      if (w_wr_div) begin
        r_div <= writedata[DIV_BITS-1:0];
      end
    end
  end

  // Blink prescaler. A DIV write restarts the half-period in the on phase,
  // taking priority over a toggle due on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= DIV_RESET;
      r_phase   <= 1'b1;
    end else if (w_wr_div) begin
      r_div_cnt <= writedata[DIV_BITS-1:0];
      r_phase   <= 1'b1;
    end else if (r_div_cnt == '0) begin
      r_div_cnt <= r_div;
      r_phase   <= ~r_phase;
    end else begin
      r_div_cnt <= r_div_cnt - {{(DIV_BITS-1){1'b0}}, 1'b1};
    end
  end

  led_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk     (clk),
    .reset_n (reset_n),
    .bright  (r_bright),
    .pwm_on  (w_pwm_on)
  );

  assign w_gate = r_en & w_pwm_on & (~r_blink | r_phase);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pat     <= '0;
      r_led_out <= '0;
    end else begin
      r_pat     <= led_in;
      r_led_out <= r_pat & {WIDTH{w_gate}};
    end
  end

  assign led_out = r_led_out;

  // Zero-wait-state read mux, independent of chipselect like the PIO.
  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_CTRL: begin
        w_rdata[EN_BIT]    = r_en;
        w_rdata[BLINK_BIT] = r_blink;
      end
      ADDR_BRIGHT: w_rdata[PWM_BITS-1:0] = r_bright;
      ADDR_DIV:    w_rdata[DIV_BITS-1:0] = r_div;
      default: begin
        w_rdata[WIDTH-1:0] = r_led_out;
        w_rdata[PHASE_BIT] = r_phase;
      end
    endcase
  end

  assign readdata = w_rdata;

endmodule

// File: tb/tb_nios_led_driver.sv
// Bench for nios_led_driver: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the LED output.
module tb_nios_led_driver;

  localparam logic [23:0] DIV_RST = 24'd4999999;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  led_in = '0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [4:0]  led_out;

  int checks = 0;
  int failures = 0;

  // Reference model state: register contents, delayed pattern/output,
  // edges since reset (PWM position) and edges since the last prescaler load.
  bit          m_en, m_blink;
  logic [7:0]  m_bright;
  logic [23:0] m_div;
  logic [4:0]  m_pat, m_led;
  longint      m_edges, m_nload;

  nios_led_driver dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .led_in     (led_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  function automatic bit m_phase();
    longint q;
    q = m_nload / (longint'(m_div) + 64'd1);
    return (q % 2) == 0;
  endfunction

  function automatic bit m_pwm_on();
    longint c;
    c = m_edges % 256;
    return (m_bright == 8'hFF) || (c < longint'(m_bright));
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r = {30'b0, m_blink, m_en};
      2'd1: r = {24'b0, m_bright};
      2'd2: r = {8'b0, m_div};
      default: begin
        r[4:0] = m_led;
        r[8]   = m_phase();
      end
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_en = 1'b1; m_blink = 1'b0; m_bright = 8'hFF; m_div = DIV_RST;
    m_pat = '0; m_led = '0; m_edges = 0; m_nload = 0;
  endtask

  // Advance the model with the inputs presented now, then take one edge.
  task automatic tick();
    bit on;
    if (!reset_n) begin
      model_reset();
    end else begin
      on = m_en && m_pwm_on() && (!m_blink || m_phase());
      m_led = on ? m_pat : 5'h00;
      m_pat = led_in;
      m_edges++;
      if (chipselect && !write_n && address == 2'd2) begin
        m_div = writedata[23:0];
        m_nload = 0;
      end else begin
        m_nload++;
      end
      if (chipselect && !write_n && address == 2'd0) begin
        m_en = writedata[0];
        m_blink = writedata[1];
      end
      if (chipselect && !write_n && address == 2'd1) m_bright = writedata[7:0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [3];
    exp_rd[0] = 32'd1; exp_rd[1] = 32'hFF; exp_rd[2] = {8'b0, DIV_RST};
    reset_n = 1'b0; led_in = 5'h1F;
    tick(); tick();
    checks++;
    if (led_out !== 5'h00) begin
      failures++; $display("FAIL reset_led_out got=%h exp=00", led_out);
    end
    for (int a = 0; a < 3; a++) begin
      address = 2'(a); #1;
      checks++;
      if (readdata !== exp_rd[a]) begin
        failures++; $display("FAIL reset_read addr=%0d got=%h exp=%h", a, readdata, exp_rd[a]);
      end
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (led_out !== 5'h00) begin
      failures++; $display("FAIL release_edge1 got=%h exp=00", led_out);
    end
    tick();
    checks++;
    if (led_out !== 5'h1F) begin
      failures++; $display("FAIL release_edge2 got=%h exp=1f", led_out);
    end
  endtask

  task automatic test_passthrough();
    led_in = 5'h0A;
    tick(); tick(); tick();
    checks++;
    if (led_out !== 5'h0A) begin
      failures++; $display("FAIL pass_steady got=%h exp=0a", led_out);
    end
    led_in = 5'h15;
    tick();
    checks++;
    if (led_out !== 5'h0A) begin
      failures++; $display("FAIL pass_t1 got=%h exp=0a", led_out);
    end
    tick();
    checks++;
    if (led_out !== 5'h15) begin
      failures++; $display("FAIL pass_t2 got=%h exp=15", led_out);
    end
  endtask

  task automatic test_pwm_duty();
    logic [7:0] br [3];
    int exp_hi [3];
    int hi;
    br[0] = 8'd64; br[1] = 8'd0; br[2] = 8'd255;
    exp_hi[0] = 128; exp_hi[1] = 0; exp_hi[2] = 512;
    led_in = 5'h1F;
    for (int k = 0; k < 3; k++) begin
      bus_write(2'd1, {24'hABCDEF, br[k]});
      tick();
      hi = 0;
      for (int c = 0; c < 512; c++) begin
        tick();
        if (led_out[0]) hi++;
      end
      checks++;
      if (hi !== exp_hi[k]) begin
        failures++; $display("FAIL pwm_duty bright=%0d got=%0d exp=%0d", br[k], hi, exp_hi[k]);
      end
    end
  endtask

  task automatic test_blink();
    logic exp;
    int bad;
    led_in = 5'h01;
    bus_write(2'd1, 32'hFF);
    bus_write(2'd0, 32'd3);
    bus_write(2'd2, 32'd3);
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp = (((i - 1) / 4) % 2) == 0;
      if (led_out[0] !== exp) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL blink_4on_4off got=%0d_wrong_cycles exp=0", bad);
    end
    repeat (5) tick();
    checks++;
    if (led_out[0] !== 1'b0) begin
      failures++; $display("FAIL blink_off_phase got=%b exp=0", led_out[0]);
    end
    bus_write(2'd2, 32'd3);
    tick();
    checks++;
    if (led_out[0] !== 1'b1) begin
      failures++; $display("FAIL blink_div_restart got=%b exp=1", led_out[0]);
    end
  endtask

  task automatic test_disable();
    logic exp_ph;
    led_in = 5'h1F;
    bus_write(2'd0, 32'd0);
    tick();
    checks++;
    if (led_out !== 5'h00) begin
      failures++; $display("FAIL disable_led_out got=%h exp=00", led_out);
    end
    bus_write(2'd2, 32'd3);
    address = 2'd3;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_ph = ((k / 4) % 2) == 0;
      checks++;
      if (readdata !== {23'b0, exp_ph, 8'h00}) begin
        failures++; $display("FAIL disable_status k=%0d got=%h exp=%h", k, readdata, {23'b0, exp_ph, 8'h00});
      end
    end
  endtask

  task automatic test_bus_edges();
    logic [31:0] exp_rd [3];
    exp_rd[0] = 32'd0; exp_rd[1] = 32'hFF; exp_rd[2] = 32'd3;
    bus_write(2'd3, 32'hFFFF_FFFF);
    address = 2'd1; writedata = 32'd0; write_n = 1'b0; chipselect = 1'b0;
    tick();
    write_n = 1'b1;
    for (int a = 0; a < 3; a++) begin
      address = 2'(a); #1;
      checks++;
      if (readdata !== exp_rd[a]) begin
        failures++; $display("FAIL ignored_write addr=%0d got=%h exp=%h", a, readdata, exp_rd[a]);
      end
    end
    bus_write(2'd2, 32'hFFFF_FFFF);
    address = 2'd2; #1;
    checks++;
    if (readdata !== 32'h00FF_FFFF) begin
      failures++; $display("FAIL div_truncate got=%h exp=00ffffff", readdata);
    end
  endtask

  task automatic test_reset_mid();
    led_in = 5'h1F;
    bus_write(2'd0, 32'd1);
    bus_write(2'd1, 32'd64);
    repeat (100) tick();
    #2 reset_n = 1'b0;
    address = 2'd1;
    #1;
    checks++;
    if (led_out !== 5'h00 || readdata !== 32'hFF) begin
      failures++; $display("FAIL async_reset led=%h bright=%h exp led=00 bright=ff", led_out, readdata);
    end
    tick(); tick();
    reset_n = 1'b1;
    bus_write(2'd1, 32'd2);
    tick();
    checks++;
    if (led_out !== 5'h1F) begin
      failures++; $display("FAIL pwm_restart_on got=%h exp=1f", led_out);
    end
    tick();
    checks++;
    if (led_out !== 5'h00) begin
      failures++; $display("FAIL pwm_restart_off got=%h exp=00", led_out);
    end
  endtask

  task automatic test_random();
    int bad_led, bad_rd;
    logic [31:0] exp;
    bad_led = 0; bad_rd = 0;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      led_in = 5'($urandom);
      address = 2'($urandom);
      chipselect = ($urandom_range(0, 9) == 0);
      write_n = ($urandom_range(0, 3) == 0);
      writedata = $urandom;
      if (address == 2'd2 && $urandom_range(0, 15) != 0) writedata = $urandom_range(0, 9);
      if (address == 2'd0 && $urandom_range(0, 3) != 0) writedata[0] = 1'b1;
      if (address == 2'd1 && $urandom_range(0, 3) == 0) writedata[7:0] = {8{writedata[31]}};
      #1;
      exp = m_read(address);
      checks++;
      if (readdata !== exp) begin
        bad_rd++; failures++;
        if (bad_rd <= 5) $display("FAIL rand_read cyc=%0d addr=%0d got=%h exp=%h", c, address, readdata, exp);
      end
      tick();
      checks++;
      if (led_out !== m_led) begin
        bad_led++; failures++;
        if (bad_led <= 5) $display("FAIL rand_led cyc=%0d got=%h exp=%h", c, led_out, m_led);
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_passthrough();
    test_pwm_duty();
    test_blink();
    test_disable();
    test_bus_edges();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
